// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch stage: machine word, fetch FSM states, word size.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface pc_fetch_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t imemload;

  modport master (output iREN, output iaddr, input ihit, input imemload);
  modport slave  (input iREN, input iaddr, output ihit, output imemload);

endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch: owns the PC, issues imem reads, applies halt/redirect/stall
// and registers each accepted word with its PC+4 for the IF/ID register.
//
// state  | meaning
// FETCH  | normal fetching from pc
// DRAIN  | request at old pc still outstanding; redirect target parked in pend_pc
// HALTED | fetch stopped until reset
module pc_fetch
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic                CLK,
  input  logic                RST,
  pc_fetch_if.master          imem,
  input  logic                stall,
  input  logic                redirect,
  input  word_t               redirect_pc,
  input  logic                halt,
  output logic                fetch_valid,
  output word_t               instr_out,
  output word_t               pcp4_out,
  output logic                halted
);

  fetch_state_t state, state_n;
  word_t        pc, pc_n;
  word_t        pend_pc, pend_pc_n;
  word_t        instr_n, pcp4_n;
  logic         valid_n, halted_n;
  word_t        pc_plus4;

  assign pc_plus4 = pc + WORD_BYTES;

  // All fetch-stage registers; reset returns to a clean FETCH at PC_INIT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= FETCH;
      pc          <= PC_INIT;
      pend_pc     <= '0;
      fetch_valid <= 1'b0;
      instr_out   <= '0;
      pcp4_out    <= '0;
      halted      <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      pend_pc     <= pend_pc_n;
      fetch_valid <= valid_n;
      instr_out   <= instr_n;
      pcp4_out    <= pcp4_n;
      halted      <= halted_n;
    end
  end

  // Next state and next pc, priority halt > redirect > stall > normal.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pend_pc_n = pend_pc;
    valid_n   = 1'b0;
    instr_n   = instr_out;
    pcp4_n    = pcp4_out;
    halted_n  = halted;
    case (state)
      FETCH: begin
        if (halt) begin
          state_n  = HALTED;
          halted_n = 1'b1;
        end else if (redirect) begin
          if (imem.ihit) begin
            pc_n = redirect_pc;
          end else begin
            pend_pc_n = redirect_pc;
            state_n   = DRAIN;
          end
        end else if (!stall && imem.ihit) begin
          instr_n = imem.imemload;
          pcp4_n  = pc_plus4;
          valid_n = 1'b1;
          pc_n    = pc_plus4;
        end
      end
      DRAIN: begin
        if (halt) begin
          state_n  = HALTED;
          halted_n = 1'b1;
        end else begin
          // A redirect arriving with the hit is newer than the parked target.
          if (redirect) pend_pc_n = redirect_pc;
          if (imem.ihit) begin
            pc_n    = redirect ? redirect_pc : pend_pc;
            state_n = FETCH;
          end
        end
      end
      HALTED: begin
        halted_n = 1'b1;
      end
      default: begin
        state_n = FETCH;
      end
    endcase
  end

  // Bus request: address always tracks pc, which is frozen while DRAIN waits.
  always_comb begin
    imem.iREN  = !RST && (state != HALTED);
    imem.iaddr = pc;
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed vector table, corner sequences, random vs model.
module tb_pc_fetch;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST = 1'b1;
  logic  stall = 1'b0, redirect = 1'b0, halt = 1'b0;
  word_t redirect_pc = '0;
  logic  fetch_valid, halted;
  word_t instr_out, pcp4_out;

  pc_fetch_if bus();

  pc_fetch #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .imem(bus),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .fetch_valid(fetch_valid), .instr_out(instr_out), .pcp4_out(pcp4_out),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  ihit, stall, redir;
    word_t rpc;
    logic  halt;
    word_t load;
    logic  e_iren;
    word_t e_iaddr;
    logic  e_fv;
    word_t e_instr, e_pcp4;
    logic  e_halted;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad = 0;

  // reference model state
  word_t m_pc, m_target, m_instr, m_pcp4;
  logic  m_waiting, m_halted, m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ih, st, rd, input word_t rpc, input logic hl,
                              input word_t ld, input logic eiren, input word_t eaddr,
                              input logic efv, input word_t einstr, epcp4, input logic ehalt);
    vec_t v;
    v.ihit = ih; v.stall = st; v.redir = rd; v.rpc = rpc; v.halt = hl; v.load = ld;
    v.e_iren = eiren; v.e_iaddr = eaddr; v.e_fv = efv; v.e_instr = einstr;
    v.e_pcp4 = epcp4; v.e_halted = ehalt;
    return v;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_target = '0; m_instr = '0; m_pcp4 = '0;
    m_waiting = 1'b0; m_halted = 1'b0; m_valid = 1'b0;
  endtask

  // One cycle of fetch behaviour described as "is a redirect target waiting?"
  task automatic model_step(input vec_t v);
    m_valid = 1'b0;
    if (m_halted) begin
    end else if (v.halt) begin
      m_halted = 1'b1; m_waiting = 1'b0;
    end else if (m_waiting) begin
      if (v.redir) m_target = v.rpc;
      if (v.ihit) begin m_pc = m_target; m_waiting = 1'b0; end
    end else if (v.redir) begin
      if (v.ihit) m_pc = v.rpc;
      else begin m_target = v.rpc; m_waiting = 1'b1; end
    end else if (v.ihit && !v.stall) begin
      m_instr = v.load; m_pcp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; bus.ihit = 1'b0; bus.imemload = '0;
    stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = '0;
    #1;
    check("rst_iren", {31'b0, bus.iREN}, 32'd0);
    check("rst_iaddr", bus.iaddr, 32'h0);
    check("rst_fv", {31'b0, fetch_valid}, 32'd0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pcp4", pcp4_out, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // Drive one cycle; use_tbl picks table constants, otherwise the model.
  task automatic run_cycle(input vec_t v, input bit use_tbl);
    @(negedge CLK);
    bus.ihit = v.ihit; bus.imemload = v.load; stall = v.stall;
    redirect = v.redir; redirect_pc = v.rpc; halt = v.halt;
    #1;
    if (use_tbl) begin
      check("iren", {31'b0, bus.iREN}, {31'b0, v.e_iren});
      check("iaddr", bus.iaddr, v.e_iaddr);
    end else begin
      check("m_iren", {31'b0, bus.iREN}, {31'b0, !m_halted});
      check("m_iaddr", bus.iaddr, m_pc);
    end
    @(posedge CLK);
    if (!use_tbl) model_step(v);
    #1;
    if (use_tbl) begin
      check("fv", {31'b0, fetch_valid}, {31'b0, v.e_fv});
      check("instr", instr_out, v.e_instr);
      check("pcp4", pcp4_out, v.e_pcp4);
      check("halted", {31'b0, halted}, {31'b0, v.e_halted});
    end else begin
      check("m_fv", {31'b0, fetch_valid}, {31'b0, m_valid});
      check("m_instr", instr_out, m_instr);
      check("m_pcp4", pcp4_out, m_pcp4);
      check("m_halted", {31'b0, halted}, {31'b0, m_halted});
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) run_cycle(tbl[i], 1'b1);
  endtask

  initial begin
    vec_t v;
    int   halt_cnt;
    bus.ihit = 1'b0; bus.imemload = '0;

    // rows 0..20: sequential fetch, DRAIN, double redirect, stall, halt
    tbl.push_back(mk(1,0,0,0,0,32'h11, 1,32'h0,   1,32'h11,32'h4,   0));
    tbl.push_back(mk(1,0,0,0,0,32'h22, 1,32'h4,   1,32'h22,32'h8,   0));
    tbl.push_back(mk(1,0,0,0,0,32'h33, 1,32'h8,   1,32'h33,32'hC,   0));
    tbl.push_back(mk(1,0,0,0,0,32'h44, 1,32'hC,   1,32'h44,32'h10,  0));
    tbl.push_back(mk(0,0,1,32'h200,0,0,1,32'h10,  0,32'h44,32'h10,  0));
    tbl.push_back(mk(0,0,0,0,0,0,      1,32'h10,  0,32'h44,32'h10,  0));
    tbl.push_back(mk(0,0,0,0,0,0,      1,32'h10,  0,32'h44,32'h10,  0));
    tbl.push_back(mk(1,0,0,0,0,32'h55, 1,32'h10,  0,32'h44,32'h10,  0));
    tbl.push_back(mk(1,0,0,0,0,32'h66, 1,32'h200, 1,32'h66,32'h204, 0));
    tbl.push_back(mk(0,0,1,32'h200,0,0,1,32'h204, 0,32'h66,32'h204, 0));
    tbl.push_back(mk(0,0,1,32'h300,0,0,1,32'h204, 0,32'h66,32'h204, 0));
    tbl.push_back(mk(1,0,0,0,0,32'h77, 1,32'h204, 0,32'h66,32'h204, 0));
    tbl.push_back(mk(1,0,0,0,0,32'h88, 1,32'h300, 1,32'h88,32'h304, 0));
    tbl.push_back(mk(1,0,1,32'h40,0,32'h99,1,32'h304,0,32'h88,32'h304,0));
    tbl.push_back(mk(1,1,0,0,0,32'hAA, 1,32'h40,  0,32'h88,32'h304, 0));
    tbl.push_back(mk(1,1,0,0,0,32'hAA, 1,32'h40,  0,32'h88,32'h304, 0));
    tbl.push_back(mk(1,0,0,0,0,32'hBB, 1,32'h40,  1,32'hBB,32'h44,  0));
    tbl.push_back(mk(1,1,1,32'h80,0,32'hCC,1,32'h44,0,32'hBB,32'h44, 0));
    tbl.push_back(mk(0,0,0,0,1,0,      1,32'h80,  0,32'hBB,32'h44,  1));
    tbl.push_back(mk(1,0,0,0,0,32'hDD, 0,32'h80,  0,32'hBB,32'h44,  1));
    tbl.push_back(mk(1,0,1,32'h123,0,0,0,32'h80,  0,32'hBB,32'h44,  1));
    // rows 21..26: wrap at top of address space, halt beats redirect in DRAIN
    tbl.push_back(mk(1,0,1,32'hFFFF_FFFC,0,32'h1,1,32'h0,0,32'h0,32'h0,0));
    tbl.push_back(mk(1,0,0,0,0,32'hDD, 1,32'hFFFF_FFFC,1,32'hDD,32'h0,0));
    tbl.push_back(mk(1,0,0,0,0,32'hEE, 1,32'h0,   1,32'hEE,32'h4,   0));
    tbl.push_back(mk(0,0,1,32'h500,0,0,1,32'h4,   0,32'hEE,32'h4,   0));
    tbl.push_back(mk(0,0,1,32'h600,1,0,1,32'h4,   0,32'hEE,32'h4,   1));
    tbl.push_back(mk(1,0,0,0,0,32'hFF, 0,32'h4,   0,32'hEE,32'h4,   1));

    do_reset();
    run_rows(0, 20);
    do_reset();
    run_rows(21, 26);

    // reset in the middle of DRAIN loses the parked target
    do_reset();
    run_cycle(mk(0,0,1,32'h700,0,0,0,0,0,0,0,0), 1'b0);
    @(negedge CLK);
    redirect = 1'b0; bus.ihit = 1'b0;
    #1 RST = 1'b1;
    #1;
    check("mid_rst_iren", {31'b0, bus.iREN}, 32'd0);
    check("mid_rst_iaddr", bus.iaddr, 32'h0);
    #1 RST = 1'b0;
    model_reset();
    run_cycle(mk(1,0,0,0,0,32'hABC,0,0,0,0,0,0), 1'b0);
    check("post_drain_rst_pcp4", pcp4_out, 32'h4);

    // randomized traffic checked against the model
    do_reset();
    halt_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      v = mk(0,0,0,0,0,0,0,0,0,0,0,0);
      v.ihit  = ($urandom_range(0, 9) < 6);
      v.stall = ($urandom_range(0, 9) < 2);
      v.redir = ($urandom_range(0, 99) < 15);
      v.rpc   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom;
      v.halt  = ($urandom_range(0, 199) == 0);
      v.load  = $urandom;
      run_cycle(v, 1'b0);
      if (m_halted) halt_cnt++;
      if (halt_cnt >= 3) begin
        halt_cnt = 0;
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage of the five-stage pipeline. It owns the program counter, drives the instruction-memory request, applies stalls, redirects and halt, and presents each accepted instruction word with its PC+4 to the IF/ID register. A one-entry redirect buffer keeps the request address stable while a fetch is outstanding. The registered fetch outputs feed IF/ID, which in turn feeds the ID/EX register.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset
- CLK  in  1  pipeline clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- ihit  in  1  instruction memory returns `imemload` for `iaddr` this cycle
- imemload  in  32  instruction word, valid when `ihit`
- stall  in  1  hazard unit holds fetch (load-use); PC held
- redirect  in  1  EX resolved taken branch/jump/JR this cycle
- redirect_pc  in  32  target PC, valid with `redirect`
- halt  in  1  HALT decoded downstream; stop fetching permanently
- iREN  out  1  instruction read request
- iaddr  out  32  request address
- fetch_valid  out  1  registered; `instr_out`/`pcp4_out` hold a new correct-path word
- instr_out  out  32  registered fetched instruction
- pcp4_out  out  32  registered PC+4 of `instr_out`
- halted  out  1  registered; fetch stopped

## Operation
- States: FETCH, DRAIN (outstanding request, redirect buffered), HALTED.
- Outputs: `iREN = !RST && state != HALTED`; `iaddr = pc`.
- Priority every cycle: halt > redirect > stall > normal.
- FETCH:
  - halt: go to HALTED. Drop `iREN`; the request may be abandoned.
  - redirect with `ihit`: discard word; `pc <= redirect_pc`; stay.
  - redirect without `ihit`: `pend_pc <= redirect_pc`; go to DRAIN; `pc` unchanged.
  - stall with `ihit`: discard word; `pc` held; same address refetched.
  - `ihit`, no stall: `instr_out <= imemload`, `pcp4_out <= pc+4`, `fetch_valid <= 1`, `pc <= pc+4`.
  - no `ihit`: hold everything.
- DRAIN:
  - `iaddr` stays at the old `pc`.
  - A new redirect overwrites `pend_pc`; latest wins.
  - On `ihit`: discard word; `pc <= redirect ? redirect_pc : pend_pc`; go to FETCH.
  - halt: go to HALTED.
- HALTED: absorbing until RST. `halted = 1`, `fetch_valid = 0`.
- `fetch_valid` is a one-cycle pulse; it is 0 in every cycle not following an accepted word. `instr_out`/`pcp4_out` retain their last value when not updated.
- Arithmetic: `pc+4` is modulo 2^32. 0xFFFF_FFFC wraps to 0x0000_0000. No alignment check; `redirect_pc[1:0]` is passed through unchanged.

## Timing
- Reset (async, immediate): pc = PC_INIT, pend_pc = 0, state = FETCH, fetch_valid = 0, instr_out = 0, pcp4_out = 0, halted = 0, iREN = 0 while RST is high.
- First request: `iREN = 1` in the first cycle after RST falls, with `iaddr = PC_INIT`.
- Latency: word accepted at edge n appears on `instr_out`/`fetch_valid` in cycle n+1.
- Throughput: with `ihit` held high and no stall, one word per cycle.
- Bus rule: while `iREN = 1` and `ihit = 0`, `iaddr` must not change. Deasserting `iREN` (halt, reset) is permitted.
- Redirect to first correct-path word:
  - 1 cycle if `ihit` coincides with `redirect`.
  - Otherwise the wait for the in-flight `ihit`, plus 1 cycle.
- Coincident cases:
  - redirect + stall: redirect wins.
  - halt + redirect: halt wins, pend_pc is ignored.
  - RST asserted mid-DRAIN: buffered target is lost and state returns to FETCH.

## Structure
- cpu_types_pkg holds:
  - `word_t` (32-bit)
  - `fetch_state_t` enum {FETCH, DRAIN, HALTED}
  - `WORD_BYTES = 4`
- Single module, no sub-module.
- Next-state/next-pc logic goes in one combinational block; registers go in one `always_ff` on `posedge CLK, posedge RST`.

## Test plan
- Reset release, PC_INIT = 0, ihit tied 1 -> iaddr 0, 4, 8 on consecutive cycles. fetch_valid high from the second cycle; pcp4_out 4, 8, 12.
- ihit low 3 cycles at pc 0x10, redirect to 0x200 in the first of them -> iaddr holds 0x10 until ihit. Word dropped (fetch_valid 0). Next iaddr is 0x200.
- In DRAIN, second redirect to 0x300 before ihit -> after ihit, iaddr 0x300; 0x200 never requested.
- stall high 2 cycles at pc 0x40 with ihit 1 -> iaddr 0x40 for 3 cycles. fetch_valid 0 during the stall; the word is delivered exactly once.
- halt with ihit low at pc 0x80 -> next cycle iREN 0, halted 1. Stays halted until RST, then iaddr = PC_INIT.
- pc = 0xFFFF_FFFC, ihit -> pcp4_out 0x0000_0000, next iaddr 0x0000_0000.
